// File: rtl/sw_port_out_queue.sv
// ---------------------------------------------------------------------------
// sw_port_out_queue
//
// Output-port queue for one switch egress port. Words routed to this port by
// the switch core are buffered in a circular buffer and presented to the port
// consumer with first-word fall-through.
//
// Handshakes:
//   producer side : a word transfers at a rising edge when in_valid && in_ready.
//                   in_valid while !in_ready discards the word (counted as a drop).
//   consumer side : the head word pops at a rising edge when read && ready.
//                   read while !ready changes nothing except the underrun flag.
//   in_ready and ready come from registered state only, so neither depends
//   combinationally on in_valid or read.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   in_data      word from the switch core
//   in_valid     in_data is valid this cycle
//   in_ready     queue can accept a word (level != DEPTH)
//   data         head-of-queue word, valid while ready=1 (holds otherwise)
//   ready        queue non-empty
//   read         consumer pops the head word this cycle
//   level        current occupancy, 0..DEPTH
//   drop_cnt     saturating count of words offered while full
//   underrun     sticky flag: read seen while ready=0
//
// Optional feature macro: SW_PORT_OUT_STATS_EN
//   defined   : drop_cnt and underrun are implemented.
//   undefined : drop_cnt and underrun are tied to 0 and no counter logic exists.
// ---------------------------------------------------------------------------
module sw_port_out_queue #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int LVL_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] data,
    output logic              ready,
    input  logic              read,
    output logic [LVL_W-1:0]  level,
    output logic [7:0]        drop_cnt,
    output logic              underrun
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    // Storage array; contents are not reset, only the pointers are.
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  level_q,  level_d;
    logic [DATA_W-1:0] data_q,   data_d;

    logic push;
    logic pop;
    logic ready_w;
    logic in_ready_w;

    assign ready_w    = (level_q != '0);
    assign in_ready_w = (level_q != FULL_LVL);

    always_comb begin
        // Full is judged on the registered level: a pop this cycle does not
        // make room for a push offered in the same cycle.
        push = in_valid && in_ready_w;
        pop  = read && ready_w;

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end

        // The head word is registered so data can hold its last value once
        // the queue empties. If the next head is the slot being written this
        // cycle (push into an empty queue, or push+pop at level 1), take the
        // incoming word directly since the array is not yet updated.
        data_d = data_q;
        if (level_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                data_d = in_data;
            end else begin
                data_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            data_q   <= data_d;
        end
    end

    assign in_ready = in_ready_w;
    assign ready    = ready_w;
    assign level    = level_q;
    assign data     = data_q;

`ifdef SW_PORT_OUT_STATS_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;
    logic       underrun_q, underrun_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (in_valid && !in_ready_w && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        underrun_d = underrun_q | (read && !ready_w);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt_q <= '0;
            underrun_q <= 1'b0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
            underrun_q <= underrun_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
    assign underrun = underrun_q;
`else
    assign drop_cnt = 8'd0;
    assign underrun = 1'b0;
`endif

endmodule
